fpna_cfg_loader: RTL and testbench

Configuration bitstream front end for the neurochip field-programmable neuron array. It accepts the serial bitstream on `bs_in` while `config_en` is high and passes it through the daisy chain on `bs_out`. At the end of the frame it checks the frame length and commits the captured bits to a shadow register, `cfg_word`. The downstream neuron and dendrite routing fabric consumes `cfg_word` in parallel, so a partial or corrupt load never reaches the array.

---
 rtl/fpna_pkg.sv | 21 ++
 rtl/fpna_cfg_shift.sv | 60 ++++++
 rtl/fpna_cfg_loader.sv | 130 +++++++++++++
 tb/tb_fpna_cfg_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpna_pkg.sv
// Shared definitions for the FPNA configuration loader.
//   FPNA_CFG_BITS : default number of configuration bits per frame
//   cfg_state_t   : loader FSM state encoding (IDLE, SHIFT, CHECK)
//   cnt_width()   : width of the frame bit counter for a given frame size
package fpna_pkg;

  localparam int FPNA_CFG_BITS = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } cfg_state_t;

  // The counter must reach CFG_BITS+2 (saturation point), so it needs to
  // represent values 0 .. CFG_BITS+2.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 3);
  endfunction

endpackage

// File: rtl/fpna_cfg_shift.sv
// Capture datapath of the configuration loader: the shift register, the
// saturating frame bit counter and, when FPNA_CFG_PARITY_EN is defined, the
// running parity of the frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   shift_en   : shift bs_in into sr this cycle (already qualified by ena)
//   clr        : this shift is the first bit of a frame (restarts cnt/par)
//   bs_in      : serial data in
//   sr         : shift register contents, newest bit in sr[0]
//   cnt        : bits shifted in this frame, saturating at CFG_BITS+2
//   par        : XOR of all bits of this frame (FPNA_CFG_PARITY_EN only)
module fpna_cfg_shift
  import fpna_pkg::*;
#(
  parameter int CFG_BITS = FPNA_CFG_BITS,
  parameter int W        = CFG_BITS,
  parameter int CW       = cnt_width(CFG_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic          clr,
  input  logic          bs_in,
  output logic [W-1:0]  sr,
`ifdef FPNA_CFG_PARITY_EN
  output logic          par,
`endif
  output logic [CW-1:0] cnt
);

  // Saturating one step past any legal frame length means an overlong frame
  // can never wrap back onto the good length.
  localparam logic [CW-1:0] CNT_MAX = CW'(CFG_BITS + 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
`ifdef FPNA_CFG_PARITY_EN
      par <= 1'b0;
`endif
    end else if (shift_en) begin
      // sr is never cleared at frame start: it is also the daisy-chain delay
      // line, so bits of the previous frame keep flowing out on bs_out.
      sr <= {sr[W-2:0], bs_in};
      if (clr) begin
        cnt <= CW'(1);
`ifdef FPNA_CFG_PARITY_EN
        par <= bs_in;
`endif
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
`ifdef FPNA_CFG_PARITY_EN
        par <= par ^ bs_in;
`endif
      end
    end
  end

endmodule

// File: rtl/fpna_cfg_loader.sv
// Configuration bitstream front end for the field-programmable neuron array.
// Shifts the serial bitstream in while config_en is high, passes it down the
// daisy chain on bs_out, and at the end of the frame commits the captured
// bits to cfg_word only if the frame length (and parity) is correct.
// Optional feature: define FPNA_CFG_PARITY_EN to append one even-parity bit
// to each frame (frame = CFG_BITS data bits + 1 parity bit).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design enable; all state holds while low
//   config_en  : frame gate, high while the bitstream is shifted in
//   bs_in      : serial config data, MSB first
//   bs_out     : serial chain output, CFG_BITS shift cycles behind bs_in
//   cfg_word   : committed configuration word
//   cfg_load   : one-cycle pulse when cfg_word updates
//   cfg_busy   : high while a frame is in SHIFT or CHECK
//   cfg_err    : sticky frame error, cleared by the next good commit
//   dbg_state  : current FSM state
// Handshake: there is no back-pressure. A frame is every enabled cycle with
// config_en high starting from IDLE; the first enabled cycle with config_en
// low ends it, and the result is presented one enabled cycle later with
// cfg_load as a single-cycle qualifier for cfg_word.
module fpna_cfg_loader
  import fpna_pkg::*;
#(
  parameter int CFG_BITS = FPNA_CFG_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                config_en,
  input  logic                bs_in,
  output logic                bs_out,
  output logic [CFG_BITS-1:0] cfg_word,
  output logic                cfg_load,
  output logic                cfg_busy,
  output logic                cfg_err,
  output cfg_state_t          dbg_state
);

`ifdef FPNA_CFG_PARITY_EN
  localparam int W = CFG_BITS + 1;
`else
  localparam int W = CFG_BITS;
`endif
  localparam int CW = cnt_width(CFG_BITS);

  cfg_state_t          state;
  logic                shift_en;
  logic                clr;
  logic [W-1:0]        sr;
  logic [CW-1:0]       cnt;
  logic                frame_good;
  logic [CFG_BITS-1:0] frame_data;
`ifdef FPNA_CFG_PARITY_EN
  logic                par;
`endif

  // A bit arriving while in CHECK is deliberately not shifted.
  assign shift_en = ena && config_en && (state == IDLE || state == SHIFT);
  assign clr      = (state == IDLE);

  fpna_cfg_shift #(
    .CFG_BITS (CFG_BITS),
    .W        (W),
    .CW       (CW)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .clr      (clr),
    .bs_in    (bs_in),
    .sr       (sr),
`ifdef FPNA_CFG_PARITY_EN
    .par      (par),
`endif
    .cnt      (cnt)
  );

`ifdef FPNA_CFG_PARITY_EN
  // Parity bit is the last one in, so the data sits one position up.
  assign frame_good = (cnt == CW'(CFG_BITS + 1)) && !par;
  assign frame_data = sr[CFG_BITS:1];
`else
  assign frame_good = (cnt == CW'(CFG_BITS));
  assign frame_data = sr[CFG_BITS-1:0];
`endif

  // Chain tap is the same in both builds; sr is a flop so bs_out is registered.
  assign bs_out    = sr[CFG_BITS-1];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg_word <= '0;
      cfg_load <= 1'b0;
      cfg_busy <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (ena) begin
      cfg_load <= 1'b0;
      case (state)
        IDLE: begin
          if (config_en) begin
            state    <= SHIFT;
            cfg_busy <= 1'b1;
          end
        end
        SHIFT: begin
          if (!config_en) state <= CHECK;
        end
        CHECK: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
          if (frame_good) begin
            cfg_word <= frame_data;
            cfg_load <= 1'b1;
            cfg_err  <= 1'b0;
          end else begin
            cfg_err  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Self-checking bench for fpna_cfg_loader with CFG_BITS = 8.
// Works in both builds; FPNA_CFG_PARITY_EN selects the frame format.
module tb_fpna_cfg_loader;
  import fpna_pkg::*;

  localparam int CB = 8;
`ifdef FPNA_CFG_PARITY_EN
  localparam int FLEN = CB + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int FLEN = CB;
  localparam bit PAR  = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          config_en;
  logic          bs_in;
  logic          bs_out;
  logic [CB-1:0] cfg_word;
  logic          cfg_load;
  logic          cfg_busy;
  logic          cfg_err;
  cfg_state_t    dbg_state;

  fpna_cfg_loader #(.CFG_BITS(CB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .cfg_word  (cfg_word),
    .cfg_load  (cfg_load),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [CB-1:0] exp_q[$];   // words expected to be committed, in order
  bit            hist[$];    // last CB bits shifted into the chain
  bit            fq[$];      // bits of the frame in progress
  logic [CB-1:0] m_word;     // model of cfg_word
  logic          m_err;      // model of cfg_err

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_bs_out();
    return (hist.size() == CB) ? 32'(hist[0]) : 32'd0;
  endfunction

  function automatic logic [63:0] good_frame(input logic [CB-1:0] d);
    if (PAR) return {55'd0, d, ^d};
    return {56'd0, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic model_reset();
    hist.delete();
    fq.delete();
    m_word = '0;
    m_err  = 1'b0;
  endtask

  task automatic shift_bit(input bit b);
    ena = 1'b1; config_en = 1'b1; bs_in = b;
    tick();
    fq.push_back(b);
    hist.push_back(b);
    if (hist.size() > CB) void'(hist.pop_front());
    check("busy_shift", 32'(cfg_busy), 32'd1);
    check("load_shift", 32'(cfg_load), 32'd0);
    check("bs_out", 32'(bs_out), exp_bs_out());
  endtask

  // ena low inside a frame: nothing may move whatever the other inputs do.
  task automatic freeze(input int n);
    for (int i = 0; i < n; i++) begin
      ena = 1'b0; config_en = 1'($urandom_range(0, 1)); bs_in = 1'($urandom_range(0, 1));
      tick();
      check("busy_frozen", 32'(cfg_busy), 32'd1);
      check("state_frozen", 32'(dbg_state), 32'(SHIFT));
      check("bs_out_frozen", 32'(bs_out), exp_bs_out());
    end
  endtask

  task automatic end_frame(input bit ce_in_check);
    bit            good;
    bit            x;
    logic [CB-1:0] w;
    ena = 1'b1; config_en = 1'b0; bs_in = 1'($urandom_range(0, 1));
    tick(); // edge E
    check("state_E", 32'(dbg_state), 32'(CHECK));
    check("busy_E", 32'(cfg_busy), 32'd1);
    check("load_E", 32'(cfg_load), 32'd0);

    good = (fq.size() == FLEN);
    x = 1'b0;
    foreach (fq[i]) x ^= fq[i];
    if (PAR && x) good = 1'b0;
    w = '0;
    if (good) begin
      for (int i = 0; i < CB; i++) w = {w[CB-2:0], fq[i]};
      exp_q.push_back(w);
      m_word = w;
      m_err  = 1'b0;
    end else begin
      m_err  = 1'b1;
    end
    fq.delete();

    // Bit offered during CHECK must be dropped.
    config_en = ce_in_check; bs_in = 1'($urandom_range(0, 1));
    tick(); // edge E+1
    check("load_E1", 32'(cfg_load), 32'(good));
    if (cfg_load && exp_q.size() > 0) check("sb_word", 32'(cfg_word), 32'(exp_q.pop_front()));
    check("word_E1", 32'(cfg_word), 32'(m_word));
    check("err_E1", 32'(cfg_err), 32'(m_err));
    check("busy_E1", 32'(cfg_busy), 32'd0);
    check("state_E1", 32'(dbg_state), 32'(IDLE));
    if (!ce_in_check) begin
      config_en = 1'b0;
      tick(); // edge E+2
      check("load_E2", 32'(cfg_load), 32'd0);
      check("word_E2", 32'(cfg_word), 32'(m_word));
    end
  endtask

  // Send n bits of v MSB first, with an optional ena-low gap before bit gap_at.
  task automatic send(input logic [63:0] v, input int n, input int gap_at,
                      input int gap_len, input bit ce_in_check);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) freeze(gap_len);
      shift_bit(v[n-1-i]);
    end
    end_frame(ce_in_check);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int            n;
    int            g;
    logic [63:0]   v;
    logic [CB-1:0] d;

    rst_n = 1'b0; ena = 1'b0; config_en = 1'b0; bs_in = 1'b0;
    model_reset();
    repeat (2) tick();
    check("rst_word", 32'(cfg_word), 32'd0);
    check("rst_load", 32'(cfg_load), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_bs_out", 32'(bs_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Idle with enable: nothing may happen.
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bs_in = 1'($urandom_range(0, 1));
      tick();
      check("idle_outputs", {20'd0, cfg_word, cfg_load, cfg_busy, cfg_err, bs_out}, 32'd0);
    end

    send(good_frame(8'hA5), FLEN, -1, 0, 1'b0);
    send(64'h55, FLEN - 1, -1, 0, 1'b0);          // short frame
    send(64'h2AA, FLEN + 1, -1, 0, 1'b0);         // long frame
    send(good_frame(8'h3C), FLEN, -1, 0, 1'b0);
    send(good_frame(8'hFF), FLEN, 4, 3, 1'b0);    // ena gap mid-frame

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_word", 32'(cfg_word), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_busy", 32'(cfg_busy), 32'd0);
    check("midrst_bs_out", 32'(bs_out), 32'd0);
    config_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // config_en raised during CHECK, frames back to back.
    send(good_frame(8'h5A), FLEN, -1, 0, 1'b1);
    send(good_frame(8'hC3), FLEN, -1, 0, 1'b0);

    // Frame long enough that a wrapping counter would alias the good length.
    v = {$urandom, $urandom};
    send(v, FLEN + 16, -1, 0, 1'b0);
    send(good_frame(8'h81), FLEN, -1, 0, 1'b0);

`ifdef FPNA_CFG_PARITY_EN
    send({55'd0, 8'hA5, 1'b0}, FLEN, -1, 0, 1'b0);
    send({55'd0, 8'h66, 1'b1}, FLEN, -1, 0, 1'b0); // bad parity
`endif

    // Random frames: mix of good and malformed lengths, gaps, CHECK overlap.
    for (int k = 0; k < 24; k++) begin
      d = CB'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        v = good_frame(d);
        n = FLEN;
      end else begin
        v = {$urandom, $urandom};
        n = $urandom_range(1, FLEN + 4);
      end
      g = (n >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
      send(v, n, g, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    config_en = 1'b0;
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
